// File: rtl/input_controller.sv
// CPU input request controller: serves a switch-bank read (confirmed by a button edge) or a
// keyboard read from a scancode FIFO, answering each request with a one-cycle ack.
module input_controller #(
    parameter int unsigned KB_DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic [1:0]                src,
    input  logic                      sw_valid,
    input  logic [12:0]               sw_data,
    input  logic                      btn_pressed,
    input  logic [7:0]                kb_data,
    input  logic                      kb_valid,
    output logic                      ack,
    output logic [13:0]               data_out,
    output logic                      err,
    output logic                      stall,
    output logic [$clog2(KB_DEPTH):0] kb_count,
    output logic                      kb_overflow
);

    localparam int unsigned AW = $clog2(KB_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StWaitSw,
        StWaitKb,
        StResp,
        StRelease
    } state_e;

    state_e        state_q, state_d;
    logic [13:0]   data_q, data_d;
    logic          err_q, err_d;
    logic          btn_prev_q, btn_prev_d;
    logic [31:0]   tmo_q, tmo_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [KB_DEPTH];

    logic full, push, pop, tmo_hit, btn_rise;

    assign full     = (count_q == (AW+1)'(KB_DEPTH));
    assign pop      = (state_q == StWaitKb) && (count_q != '0);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push     = kb_valid && (!full || pop);
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_q == 32'(TIMEOUT_CYCLES - 1));
    assign btn_rise = btn_pressed && !btn_prev_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
        ovf_d = ovf_q | (kb_valid && full && !pop);
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        err_d      = err_q;
        btn_prev_d = btn_prev_q;
        tmo_d      = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    tmo_d = '0;
                    if (src == 2'd1) begin
                        btn_prev_d = btn_pressed;
                        state_d    = StWaitSw;
                    end else if (src == 2'd2) begin
                        state_d = StWaitKb;
                    end else begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StWaitSw: begin
                btn_prev_d = btn_pressed;
                tmo_d      = tmo_q + 32'd1;
                if (btn_rise && sw_valid) begin
                    data_d  = {1'b0, sw_data};
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (tmo_hit) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StWaitKb: begin
                tmo_d = tmo_q + 32'd1;
                if (pop) begin
                    data_d  = {6'b0, mem_q[rd_ptr_q]};
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (tmo_hit) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp:    state_d = StRelease;
            StRelease: if (!req) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            data_q     <= '0;
            err_q      <= 1'b0;
            btn_prev_q <= 1'b0;
            tmo_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            err_q      <= err_d;
            btn_prev_q <= btn_prev_d;
            tmo_q      <= tmo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= kb_data;
        end
    end

    assign ack         = (state_q == StResp);
    assign data_out    = data_q;
    assign err         = err_q;
    assign kb_count    = count_q;
    assign kb_overflow = ovf_q;
    assign stall       = ((state_q == StIdle) && req) || (state_q == StWaitSw) ||
                         (state_q == StWaitKb);

endmodule

// File: tb/tb_input_controller.sv
// Directed bench for input_controller: expected responses are queued at issue time and a
// negedge monitor checks each ack against the queue head.
module tb_input_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  src = 2'd0;
    logic        sw_valid = 1'b0;
    logic [12:0] sw_data = '0;
    logic        btn_pressed = 1'b0;
    logic [7:0]  kb_data = '0;
    logic        kb_valid = 1'b0;
    logic        ack;
    logic [13:0] data_out;
    logic        err;
    logic        stall;
    logic [2:0]  kb_count;
    logic        kb_overflow;

    int          checks = 0;
    int          errors = 0;
    logic [14:0] exp_q [$];
    logic [14:0] mon_e;

    input_controller #(
        .KB_DEPTH      (4),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .src        (src),
        .sw_valid   (sw_valid),
        .sw_data    (sw_data),
        .btn_pressed(btn_pressed),
        .kb_data    (kb_data),
        .kb_valid   (kb_valid),
        .ack        (ack),
        .data_out   (data_out),
        .err        (err),
        .stall      (stall),
        .kb_count   (kb_count),
        .kb_overflow(kb_overflow)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=1 data=%0h expected no pending response",
                         data_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_data", 32'(data_out), 32'(mon_e[13:0]));
                check("resp_err", 32'(err), 32'(mon_e[14]));
            end
        end
    end

    task automatic wait_ack(input int bound, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < bound);
        if (!ack) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack after %0d edges expected ack", n);
        end
    endtask

    task automatic do_req(input logic [1:0] s, input logic [13:0] d, input logic e,
                          input int lat);
        int n;
        exp_q.push_back({e, d});
        src = s;
        req = 1'b1;
        wait_ack(20, n);
        check("req_latency", 32'(n), 32'(lat));
    endtask

    task automatic finish_req();
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        kb_data  = b;
        kb_valid = 1'b1;
        @(posedge clk);
        #1;
        kb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_count", 32'(kb_count), 0);
        check("rst_ovf", 32'(kb_overflow), 0);
        check("rst_stall", 32'(stall), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single keyboard byte, two-edge latency
        push(8'h1C);
        check("kb_count_one", 32'(kb_count), 1);
        do_req(2'd2, 14'h001C, 1'b0, 2);
        finish_req();
        check("kb_count_empty", 32'(kb_count), 0);

        // Button held before the request must not confirm
        btn_pressed = 1'b1;
        sw_valid    = 1'b1;
        sw_data     = 13'h0ABC;
        exp_q.push_back({1'b0, 14'h0ABC});
        src = 2'd1;
        req = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("sw_held_no_ack", 32'(ack), 0);
        end
        btn_pressed = 1'b0;
        @(posedge clk);
        #1;
        check("sw_release_no_ack", 32'(ack), 0);
        btn_pressed = 1'b1;
        wait_ack(3, n);
        check("sw_edge_latency", 32'(n), 1);
        finish_req();
        btn_pressed = 1'b0;

        // Button edge with the bank disabled is ignored
        sw_valid = 1'b0;
        sw_data  = 13'h0123;
        exp_q.push_back({1'b0, 14'h0123});
        src = 2'd1;
        req = 1'b1;
        @(posedge clk);
        #1;
        btn_pressed = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("sw_invalid_no_ack", 32'(ack), 0);
        end
        btn_pressed = 1'b0;
        sw_valid    = 1'b1;
        @(posedge clk);
        #1;
        btn_pressed = 1'b1;
        wait_ack(3, n);
        check("sw_valid_latency", 32'(n), 1);
        finish_req();
        btn_pressed = 1'b0;

        // Full FIFO: simultaneous push and pop keeps count, no overflow
        for (int i = 1; i <= 4; i++) push(8'(i));
        check("full_count", 32'(kb_count), 4);
        check("full_no_ovf", 32'(kb_overflow), 0);
        fork
            do_req(2'd2, 14'h0001, 1'b0, 2);
            begin
                @(posedge clk);
                #1;
                kb_data  = 8'h05;
                kb_valid = 1'b1;
                @(posedge clk);
                #1;
                kb_valid = 1'b0;
            end
        join
        finish_req();
        check("pushpop_count", 32'(kb_count), 4);
        check("pushpop_no_ovf", 32'(kb_overflow), 0);
        for (int i = 2; i <= 5; i++) begin
            do_req(2'd2, 14'(i), 1'b0, 2);
            finish_req();
        end
        check("drained_count", 32'(kb_count), 0);

        // Invalid sources: immediate error ack, no repeat while req held
        do_req(2'd3, 14'h0000, 1'b1, 1);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("release_no_ack", 32'(ack), 0);
        end
        finish_req();
        do_req(2'd0, 14'h0000, 1'b1, 1);
        finish_req();

        // Timeout on an empty FIFO: 1 edge into WAIT_KB plus 10 cycles
        do_req(2'd2, 14'h0000, 1'b1, 11);
        finish_req();

        // Overflow: fifth byte dropped, first four returned in order
        for (int i = 1; i <= 5; i++) push(8'(i));
        check("ovf_flag", 32'(kb_overflow), 1);
        check("ovf_count", 32'(kb_count), 4);
        for (int i = 1; i <= 4; i++) begin
            do_req(2'd2, 14'(i), 1'b0, 2);
            finish_req();
        end
        check("ovf_sticky", 32'(kb_overflow), 1);

        // Reset while in WAIT_KB with two bytes queued
        push(8'hAA);
        push(8'hBB);
        src = 2'd2;
        req = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(kb_count), 0);
        check("mid_rst_data", 32'(data_out), 0);
        check("mid_rst_ack", 32'(ack), 0);
        check("mid_rst_ovf", 32'(kb_overflow), 0);
        check("mid_rst_stall_req", 32'(stall), 1);
        req = 1'b0;
        #1;
        check("mid_rst_stall_idle", 32'(stall), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back({1'b0, 14'h005A});
        src = 2'd2;
        req = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("post_rst_wait_ack", 32'(ack), 0);
            check("post_rst_stall", 32'(stall), 1);
        end
        push(8'h5A);
        check("push_not_same_cycle", 32'(ack), 0);
        wait_ack(3, n);
        check("post_rst_latency", 32'(n), 1);
        finish_req();

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
